// File: rtl/cam_stream_gen.sv
// -----------------------------------------------------------------------------
// cam_stream_gen
// Generates camera-style pixel streaming (vsync/href/d) from a frame buffer so
// that an OV7670-style capture block can be exercised without a real sensor.
// A frame is VSYNC, then back porch, then IMG_H lines of (IMG_W active pixels +
// HBLANK blank cycles), then front porch. Every period is counted in pclk
// cycles, with one line period LP = IMG_W + HBLANK.
//
// Ports:
//   pclk        - the single clock; all logic on its rising edge
//   rst         - asynchronous active-high reset
//   enable      - run frames back to back while high (sampled at frame end)
//   raddr[14:0] - frame-buffer read address, y*IMG_W + x for each pixel
//   rdata[7:0]  - frame-buffer data, valid one pclk edge after raddr
//   vsync, href - camera framing signals, aligned with d
//   d[7:0]      - grayscale pixel byte, 0 whenever href is low
//   frame_start - one-cycle pulse when a frame begins
//   busy        - high from frame start until the end of front porch
//
// Build option:
//   CAM_STREAM_GEN_TESTPAT_EN - when defined, d carries x[7:0] ^ y[7:0]
//   instead of rdata; timing and raddr are unchanged.
//
// HBLANK and the porch/vsync line counts are assumed to be at least 1.
// -----------------------------------------------------------------------------
module cam_stream_gen #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int HBLANK      = 16,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 2,
    parameter int VFP_LINES   = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    output logic [14:0] raddr,
    input  logic [7:0]  rdata,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_start,
    output logic        busy
);

    localparam int LP      = IMG_W + HBLANK;
    localparam int VS_CYC  = VSYNC_LINES * LP;
    localparam int VBP_CYC = VBP_LINES * LP;
    localparam int VFP_CYC = VFP_LINES * LP;
    localparam int MAX_A   = (VS_CYC > VBP_CYC) ? VS_CYC : VBP_CYC;
    localparam int MAX_B   = (VFP_CYC > HBLANK) ? VFP_CYC : HBLANK;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int X_W     = $clog2(IMG_W + 1);
    localparam int Y_W     = $clog2(IMG_H + 1);

    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VS_CYC - 1);
    localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(VBP_CYC - 1);
    localparam logic [CNT_W-1:0] VFP_LAST = CNT_W'(VFP_CYC - 1);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_HBL,
        S_VFP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [14:0]      r_raddr;
    logic             r_frameStart;
    logic             r_busy;

    // Two-stage alignment pipeline: stage 1 lines up with rdata coming back
    // from the buffer, stage 2 is the visible output.
    logic             r_act1;
    logic             r_vs1;
    logic             r_href;
    logic             r_vsync;
    logic [7:0]       r_d;

`ifdef CAM_STREAM_GEN_TESTPAT_EN
    logic [7:0]       r_tp1;
    logic [15:0]      w_x16;
    logic [15:0]      w_y16;
    assign w_x16 = 16'(r_x);
    assign w_y16 = 16'(r_y);
`endif

    // Frame sequencer. raddr is kept as a running address rather than
    // y*IMG_W + x: it restarts at 0 on the first pixel and steps by one on
    // every pixel, including the step from the last pixel of a line into
    // the first pixel of the next, which yields the same value with no
    // multiplier. Outside ACTIVE it simply holds.
    // enable is only looked at in IDLE and at the end of front porch, so a
    // frame already under way always runs to completion.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_raddr      <= '0;
            r_frameStart <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frameStart <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state      <= S_VSYNC;
                        r_cnt        <= '0;
                        r_frameStart <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_VSYNC: begin
                    if (r_cnt == VS_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_VBP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_VBP: begin
                    if (r_cnt == VBP_LAST) begin
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_raddr <= '0;
                        r_state <= S_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (r_x == X_LAST) begin
                        r_x     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_HBL;
                    end else begin
                        r_x     <= r_x + 1'b1;
                        r_raddr <= r_raddr + 15'd1;
                    end
                end
                S_HBL: begin
                    if (r_cnt == HB_LAST) begin
                        r_cnt <= '0;
                        if (r_y == Y_LAST) begin
                            r_y     <= '0;
                            r_state <= S_VFP;
                        end else begin
                            r_y     <= r_y + 1'b1;
                            r_raddr <= r_raddr + 15'd1;
                            r_state <= S_ACTIVE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_VFP: begin
                    if (r_cnt == VFP_LAST) begin
                        r_cnt <= '0;
                        if (enable) begin
                            r_state      <= S_VSYNC;
                            r_frameStart <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output alignment. The buffer answers one edge after raddr, so the
    // framing flags are delayed by two edges to land in the same cycle as the
    // byte registered from rdata. d is forced to zero whenever href is low so
    // blanking never leaks stale buffer data.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_act1  <= 1'b0;
            r_vs1   <= 1'b0;
            r_href  <= 1'b0;
            r_vsync <= 1'b0;
            r_d     <= 8'd0;
`ifdef CAM_STREAM_GEN_TESTPAT_EN
            r_tp1   <= 8'd0;
`endif
        end else begin
            r_act1  <= (r_state == S_ACTIVE);
            r_vs1   <= (r_state == S_VSYNC);
            r_href  <= r_act1;
            r_vsync <= r_vs1;
`ifdef CAM_STREAM_GEN_TESTPAT_EN
            r_tp1   <= w_x16[7:0] ^ w_y16[7:0];
            r_d     <= r_act1 ? r_tp1 : 8'd0;
`else
            r_d     <= r_act1 ? rdata : 8'd0;
`endif
        end
    end

    assign raddr       = r_raddr;
    assign vsync       = r_vsync;
    assign href        = r_href;
    assign d           = r_d;
    assign frame_start = r_frameStart;
    assign busy        = r_busy;

endmodule

// File: tb/tb_cam_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_cam_stream_gen
// Directed bench for cam_stream_gen at default parameters. A frame-position
// model (cycles since frame_start) predicts every output on every cycle; a few
// hand-computed literals pin frame statistics and specific pixel bytes.
// -----------------------------------------------------------------------------
module tb_cam_stream_gen;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int HB   = 16;
    localparam int LP   = W + HB;
    localparam int VSC  = 3 * LP;
    localparam int ACT0 = (3 + 2) * LP;
    localparam int FP   = (3 + 2 + H + 2) * LP;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [14:0] raddr;
    logic [7:0]  rdata = 8'd0;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_start;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    cam_stream_gen dut (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (enable),
        .raddr       (raddr),
        .rdata       (rdata),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .frame_start (frame_start),
        .busy        (busy)
    );

    // Frame buffer contents: mem[a] = a[7:0], or all 0xFF in test-pattern
    // builds to show rdata is ignored there.
    function automatic logic [7:0] memByte(input logic [14:0] a);
`ifdef CAM_STREAM_GEN_TESTPAT_EN
        return 8'hFF;
`else
        return a[7:0];
`endif
    endfunction

    // Synchronous-read buffer: data for an address appears one edge later.
    always @(posedge pclk) rdata <= memByte(raddr);

    // Frame geometry as plain arithmetic on the frame position q.
    function automatic bit isActive(input int q);
        return (q >= ACT0) && (q < ACT0 + H * LP) && (((q - ACT0) % LP) < W);
    endfunction

    function automatic int pixX(input int q);
        return (q - ACT0) % LP;
    endfunction

    function automatic int pixY(input int q);
        return (q - ACT0) / LP;
    endfunction

    function automatic logic [7:0] pixByte(input int q);
`ifdef CAM_STREAM_GEN_TESTPAT_EN
        return 8'(pixX(q) ^ pixY(q));
`else
        return memByte(15'(pixY(q) * W + pixX(q)));
`endif
    endfunction

    // Model state: whether a frame is running, and position p in the frame.
    bit          mRun = 1'b0;
    int          p = 0;
    logic [14:0] mRaddr = 15'd0;
    bit          chkOn = 1'b0;

    always @(posedge pclk) begin
        if (rst) begin
            mRun   = 1'b0;
            p      = 0;
            mRaddr = 15'd0;
        end else begin
            if (!mRun) begin
                if (enable) begin
                    mRun = 1'b1;
                    p    = 0;
                end
            end else if (p == FP - 1) begin
                if (enable) p = 0;
                else mRun = 1'b0;
            end else begin
                p = p + 1;
            end
            if (mRun && isActive(p)) mRaddr = 15'(pixY(p) * W + pixX(p));
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge pclk) begin : cmpProc
        logic        eFs, eB, eV, eH;
        logic [7:0]  eD;
        logic [14:0] eA;
        if (chkOn) begin
            if (rst) begin
                eFs = 0; eB = 0; eV = 0; eH = 0; eD = 8'd0; eA = 15'd0;
            end else begin
                eFs = mRun && (p == 0);
                eB  = mRun;
                eV  = mRun && (p >= 2) && (p - 2 < VSC);
                eH  = mRun && isActive(p - 2);
                eD  = eH ? pixByte(p - 2) : 8'd0;
                eA  = mRaddr;
            end
            checks++;
            if ({frame_start, busy, vsync, href, d, raddr} !== {eFs, eB, eV, eH, eD, eA}) begin
                errors++;
                $display("[TB] FAIL outputs @%0t got fs=%b busy=%b vs=%b href=%b d=%02h raddr=%0d, expected fs=%b busy=%b vs=%b href=%b d=%02h raddr=%0d",
                         $time, frame_start, busy, vsync, href, d, raddr, eFs, eB, eV, eH, eD, eA);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic applyStimulus(input logic newRst, input logic newEnable);
        @(posedge pclk);
        #1;
        rst    = newRst;
        enable = newEnable;
    endtask

    // Leaves the caller on the negedge where frame_start is seen.
    task automatic waitFrameStart(input string name, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge pclk);
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, int'(seen), 1);
    endtask

    // Called on the frame_start negedge; walks one full frame period.
    task automatic measureFrame();
        int vsN = 0, hN = 0, bursts = 0, both = 0;
        logic prevH = 1'b0;
        int d1 = -1, d160 = -1, d161 = -1, d486 = -1;
        for (int c = 0; c < FP; c++) begin
            if (c > 0) @(negedge pclk);
            if (vsync === 1'b1) vsN++;
            if (vsync === 1'b1 && href === 1'b1) both++;
            if (href === 1'b1) begin
                hN++;
                if (!prevH) bursts++;
                if (hN == 1)   d1   = int'(d);
                if (hN == 160) d160 = int'(d);
                if (hN == 161) d161 = int'(d);
                if (hN == 486) d486 = int'(d);
            end
            prevH = href;
        end
        checkOutput("vsync_high_cycles", vsN, 528);
        checkOutput("href_high_cycles", hN, 19200);
        checkOutput("href_bursts", bursts, 120);
        checkOutput("vsync_href_overlap", both, 0);
        checkOutput("d_first_pixel", d1, 8'h00);
        checkOutput("d_pixel_160", d160, 8'h9F);
`ifdef CAM_STREAM_GEN_TESTPAT_EN
        checkOutput("d_line1_pixel0", d161, 8'h01);
        checkOutput("d_y3_x5", d486, 8'h06);
`else
        checkOutput("d_line1_pixel0", d161, 8'hA0);
        checkOutput("d_y3_x5", d486, 8'hE5);
`endif
        @(negedge pclk);
        checkOutput("frame_period_next_start", int'(frame_start), 1);
    endtask

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainSeq
        int k;
        int fsN;
        int busyN;

        // Reset state.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chkOn = 1'b1;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        checkOutput("reset_vsync", int'(vsync), 0);
        checkOutput("reset_href", int'(href), 0);
        checkOutput("reset_d", int'(d), 0);
        checkOutput("reset_raddr", int'(raddr), 0);

        // Release with enable low: stays idle.
        applyStimulus(1'b0, 1'b0);
        repeat (5) @(negedge pclk);
        checkOutput("idle_without_enable", int'(busy), 0);

        // Start a frame, stop in the middle of line 50 (pixel 28 on d).
        applyStimulus(1'b0, 1'b1);
        waitFrameStart("first_frame_start", 4);
        repeat (ACT0 + 50 * LP + 30) @(negedge pclk);
        checkOutput("line50_href", int'(href), 1);
`ifdef CAM_STREAM_GEN_TESTPAT_EN
        checkOutput("line50_d", int'(d), 46);
`else
        checkOutput("line50_d", int'(d), 8'h5C);
`endif
        checkOutput("line50_raddr", int'(raddr), 8030);

        // Reset mid-line: outputs clear in the same cycle.
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("midreset_vsync", int'(vsync), 0);
        checkOutput("midreset_href", int'(href), 0);
        checkOutput("midreset_d", int'(d), 0);
        checkOutput("midreset_raddr", int'(raddr), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        repeat (2) @(posedge pclk);
        applyStimulus(1'b0, 1'b1);

        // Fresh frame with enable held, then back-to-back second frame.
        waitFrameStart("restart_frame_start", 4);
        measureFrame();

        // Drop enable early in the second frame; it must still complete.
        repeat (1000) @(negedge pclk);
        k = 1000;
        applyStimulus(1'b0, 1'b0);
        for (int n = 0; n < FP; n++) begin
            @(negedge pclk);
            k++;
            if (busy !== 1'b1) break;
        end
        checkOutput("enable_drop_frame_len", k, FP);
        fsN = 0;
        busyN = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge pclk);
            if (frame_start === 1'b1) fsN++;
            if (busy === 1'b1) busyN++;
        end
        checkOutput("idle_after_drop_starts", fsN, 0);
        checkOutput("idle_after_drop_busy", busyN, 0);

        // Single-cycle enable pulse: exactly one frame.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        fsN = 0;
        busyN = 0;
        for (int n = 0; n < FP + 200; n++) begin
            @(negedge pclk);
            if (frame_start === 1'b1) fsN++;
            if (busy === 1'b1) busyN++;
        end
        checkOutput("pulse_frame_starts", fsN, 1);
        checkOutput("pulse_busy_cycles", busyN, 22352);
        checkOutput("pulse_end_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
